input_capture_unit: RTL and testbench

//   Operator-input stage feeding the data_input leg of the write-back data mux (MUX_write=3).
//   On an IN instruction it stalls the CPU, waits for a debounced confirm-button press, then

---
 rtl/input_capture_unit.sv | 152 +++++++++++++++
 tb/tb_input_capture_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_capture_unit.sv
// -----------------------------------------------------------------------------
// input_capture_unit
//
// Operator-input stage for the IN instruction. While an IN is pending, the CPU
// is stalled until the operator presses the confirm button. The button is
// debounced before it is used. On the press, the board switches are latched
// into data_input, zero-extended to 32 bits. The stall is then released for
// one cycle so the register file can write the value. No further capture is
// accepted until the button has been released.
//
// Ports
//   clock           in   1             system clock, rising edge
//   reset_n         in   1             asynchronous active-low reset
//   input_request   in   1             current instruction is IN
//   switches        in   SWITCH_WIDTH  raw board switches (asynchronous)
//   confirm_button  in   1             raw push-button, active-high, bouncy
//   data_input      out  32            captured switch value, zero-extended
//   stall           out  1             hold PC / suppress register write
//   input_pending   out  1             waiting for operator press (LED)
// -----------------------------------------------------------------------------
module input_capture_unit #(
  parameter int SWITCH_WIDTH    = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    input_request,
  input  logic [SWITCH_WIDTH-1:0] switches,
  input  logic                    confirm_button,
  output logic [31:0]             data_input,
  output logic                    stall,
  output logic                    input_pending
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CAPTURED     = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  function automatic logic [31:0] zero_extend(input logic [SWITCH_WIDTH-1:0] v);
    zero_extend = 32'(v);
  endfunction

  logic                    btn_sync_p0;
  logic                    btn_sync_p1;
  logic [SWITCH_WIDTH-1:0] sw_sync_p0;
  logic [SWITCH_WIDTH-1:0] sw_sync_p1;
  logic [CNT_WIDTH-1:0]    db_cnt;
  logic                    btn_stable;
  logic                    btn_stable_q;
  logic                    press_event;
  state_t                  state_q;
  state_t                  state_d;
  logic                    capture_en;
  logic                    stall_raw;

  // ---- stage p0/p1: two-flop synchronisers on all asynchronous inputs ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_sync_p0 <= confirm_button;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= switches;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  // ---- debounce: accept a new button level after DEBOUNCE_CYCLES of disagreement ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt       <= '0;
      btn_stable   <= 1'b0;
      btn_stable_q <= 1'b0;
    end else begin
      btn_stable_q <= btn_stable;
      if (btn_sync_p1 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        db_cnt     <= '0;
        btn_stable <= ~btn_stable;
      end else begin
        db_cnt <= db_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign press_event = btn_stable & ~btn_stable_q;

  // ---- control FSM ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    stall_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall in the same cycle the IN appears so the PC never slips past it.
        stall_raw = input_request;
        if (input_request) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        stall_raw = 1'b1;
        if (press_event) begin
          capture_en = 1'b1;
          state_d    = CAPTURED;
        end else if (!input_request) begin
          state_d = IDLE;
        end
      end
      CAPTURED: begin
        // Stall low here: the IN retires on this edge with the fresh value.
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // A following IN must wait for release and then a fresh press.
        stall_raw = input_request;
        if (!btn_stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces stall low immediately, even with an IN still on the bus.
  assign stall         = stall_raw & reset_n;
  assign input_pending = (state_q == WAIT_PRESS);

  // ---- capture register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_input <= '0;
    end else if (capture_en) begin
      data_input <= zero_extend(sw_sync_p1);
    end
  end

endmodule

// File: tb/tb_input_capture_unit.sv
module tb_input_capture_unit;

  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        input_request;
  logic [15:0] switches;
  logic        confirm_button;
  logic [31:0] data_input;
  logic        stall;
  logic        input_pending;

  int checks   = 0;
  int failures = 0;

  input_capture_unit #(
    .SWITCH_WIDTH   (16),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .input_request (input_request),
    .switches      (switches),
    .confirm_button(confirm_button),
    .data_input    (data_input),
    .stall         (stall),
    .input_pending (input_pending)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: button seen 2 cycles late; a level is accepted once it
  // has disagreed with the accepted level for DC consecutive cycles. The
  // handshake is tracked as three flags: waiting for press, capture cycle,
  // and waiting for the button to go away.
  logic        m_s1, m_s2, m_db, m_prev;
  logic [15:0] m_w1, m_w2;
  int          m_run;
  logic        m_wait, m_cap, m_hold;
  logic [31:0] m_data;

  wire m_press = m_db & ~m_prev;
  wire m_idle  = ~(m_wait | m_cap | m_hold);
  wire m_stall = reset_n & ((m_idle & input_request) | m_wait | (m_hold & input_request));

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= 0; m_s2 <= 0; m_db <= 0; m_prev <= 0;
      m_w1 <= 0; m_w2 <= 0; m_run <= 0;
      m_wait <= 0; m_cap <= 0; m_hold <= 0; m_data <= 0;
    end else begin
      m_s1   <= confirm_button;
      m_s2   <= m_s1;
      m_w1   <= switches;
      m_w2   <= m_w1;
      m_prev <= m_db;
      if (m_s2 == m_db) m_run <= 0;
      else if (m_run + 1 >= DC) begin m_run <= 0; m_db <= m_s2; end
      else m_run <= m_run + 1;
      m_wait <= (m_idle && input_request) || (m_wait && !m_press && input_request);
      m_cap  <= m_wait && m_press;
      m_hold <= m_cap || (m_hold && m_db);
      if (m_wait && m_press) m_data <= {16'h0000, m_w2};
    end
  end

  // One clock edge, then settle to just after the following falling edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; input_request = 1'b0; confirm_button = 1'b1; switches = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({data_input, stall, input_pending} !== 34'h0) begin
        failures++;
        $display("FAIL reset_hold: data=%h stall=%b pend=%b, required 0/0/0", data_input, stall, input_pending);
      end
    end
    confirm_button = 1'b0; switches = 16'h0000;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({data_input, stall, input_pending} !== {m_data, m_stall, m_wait}) begin
        failures++;
        $display("FAIL reset_exit: got %h/%b/%b model %h/%b/%b", data_input, stall, input_pending, m_data, m_stall, m_wait);
      end
    end
  endtask

  task automatic test_clean_in();
    int k;
    switches = 16'h00A5; input_request = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL clean_stall_same_cycle: stall=%b required 1", stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({data_input, stall, input_pending} !== {m_data, m_stall, m_wait}) begin
        failures++;
        $display("FAIL clean_wait: got %h/%b/%b model %h/%b/%b", data_input, stall, input_pending, m_data, m_stall, m_wait);
      end
    end
    confirm_button = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (!stall) break;
    end
    checks++;
    if (k !== 7) begin failures++; $display("FAIL clean_latency: edges=%0d required 7", k); end
    checks++;
    if (data_input !== 32'h000000A5) begin failures++; $display("FAIL clean_data: data=%h required 000000a5", data_input); end
    input_request = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({data_input, stall, input_pending} !== {m_data, m_stall, m_wait}) begin
        failures++;
        $display("FAIL clean_hold: got %h/%b/%b model %h/%b/%b", data_input, stall, input_pending, m_data, m_stall, m_wait);
      end
    end
    confirm_button = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_bounce();
    int k;
    logic [15:0] sw;
    sw = 16'($urandom);
    switches = sw; input_request = 1'b1;
    step(); step();
    for (int i = 0; i < 6; i++) begin
      confirm_button = ~confirm_button;
      step(); step();
      checks++;
      if (stall !== 1'b1 || input_pending !== 1'b1) begin
        failures++;
        $display("FAIL bounce_no_capture: stall=%b pend=%b required 1/1", stall, input_pending);
      end
    end
    confirm_button = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (!stall) break;
    end
    checks++;
    if (k !== 7) begin failures++; $display("FAIL bounce_latency: edges=%0d required 7", k); end
    checks++;
    if (data_input !== {16'h0000, sw}) begin failures++; $display("FAIL bounce_data: data=%h required %h", data_input, {16'h0000, sw}); end
    input_request = 1'b0;
    step(); step(); step();
    confirm_button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({data_input, stall, input_pending} !== {m_data, m_stall, m_wait}) begin
        failures++;
        $display("FAIL bounce_settle: got %h/%b/%b model %h/%b/%b", data_input, stall, input_pending, m_data, m_stall, m_wait);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [15:0] sw;
    sw = 16'($urandom_range(0, 16'hFFFE));
    switches = sw; input_request = 1'b1;
    step();
    confirm_button = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (!stall) break;
    end
    checks++;
    if (k !== 7) begin failures++; $display("FAIL b2b_first_latency: edges=%0d required 7", k); end
    switches = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (stall !== 1'b1 || data_input !== {16'h0000, sw}) begin
        failures++;
        $display("FAIL b2b_held: stall=%b data=%h required 1/%h", stall, data_input, {16'h0000, sw});
      end
    end
    confirm_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL b2b_released: stall=%b required 1", stall); end
    end
    checks++;
    if (input_pending !== 1'b1) begin failures++; $display("FAIL b2b_pending: pend=%b required 1", input_pending); end
    confirm_button = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (!stall) break;
    end
    checks++;
    if (k !== 7) begin failures++; $display("FAIL b2b_second_latency: edges=%0d required 7", k); end
    checks++;
    if (data_input !== 32'h0000FFFF) begin failures++; $display("FAIL b2b_data: data=%h required 0000ffff", data_input); end
    input_request = 1'b0;
    step(); step();
    confirm_button = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_idle_press();
    input_request = 1'b0; switches = 16'h1234;
    confirm_button = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) confirm_button = 1'b0;
      step();
      checks++;
      if (stall !== 1'b0 || data_input !== 32'h0000FFFF || input_pending !== 1'b0) begin
        failures++;
        $display("FAIL idle_press: stall=%b data=%h pend=%b required 0/0000ffff/0", stall, data_input, input_pending);
      end
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_wait();
    int k;
    logic [15:0] sw;
    input_request = 1'b1;
    step(); step(); step();
    checks++;
    if (input_pending !== 1'b1) begin failures++; $display("FAIL rstw_pending: pend=%b required 1", input_pending); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({data_input, stall, input_pending} !== 34'h0) begin
      failures++;
      $display("FAIL rstw_immediate: data=%h stall=%b pend=%b required 0/0/0", data_input, stall, input_pending);
    end
    step(); step();
    sw = 16'($urandom);
    switches = sw;
    reset_n = 1'b1;
    confirm_button = 1'b1;
    for (k = 1; k <= 20; k++) begin
      step();
      if (!stall) break;
    end
    checks++;
    if (k !== 7) begin failures++; $display("FAIL rstw_latency: edges=%0d required 7", k); end
    checks++;
    if (data_input !== {16'h0000, sw}) begin failures++; $display("FAIL rstw_data: data=%h required %h", data_input, {16'h0000, sw}); end
    input_request = 1'b0;
    step(); step();
    confirm_button = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 40; it++) begin
      confirm_button = 1'($urandom);
      if ($urandom_range(0, 3) == 0) input_request = ~input_request;
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        switches = 16'($urandom);
        step();
        checks++;
        if ({data_input, stall, input_pending} !== {m_data, m_stall, m_wait}) begin
          failures++;
          $display("FAIL random_vs_model: got %h/%b/%b model %h/%b/%b", data_input, stall, input_pending, m_data, m_stall, m_wait);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_in();
    test_bounce();
    test_back_to_back();
    test_idle_press();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
